// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared keypad scan types, matrix size and idle code
package whack_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_e;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam logic [2:0] DEFAULT_IDLE_CODE = 3'b111;

    // Lowest-index active-low column; only meaningful when some bit is low.
    function automatic logic [1:0] lowest_low(input logic [KEY_COLS-1:0] cols);
        lowest_low = 2'd0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchroniser, resets to all-ones (idle pull-ups)
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 keypad row scan, column debounce, key coordinates
module key_matrix_scan
    import whack_pkg::*;
#(
    parameter int         DWELL     = 1000,
    parameter int         DEB_CNT   = 10,
    parameter logic [2:0] IDLE_CODE = DEFAULT_IDLE_CODE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_COLS-1:0] kb_col_in,
    output logic [KEY_ROWS-1:0] kb_row_out,
    output logic [2:0]          row,
    output logic [2:0]          col,
    output logic                pressed,
    output logic                press_pulse
);

    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int DEB_W   = $clog2(DEB_CNT + 1);
    localparam int ROW_W   = $clog2(KEY_ROWS);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEB_CNT);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

    logic [KEY_COLS-1:0] col_s;
    scan_state_e         state_q, state_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [ROW_W-1:0]    row_idx_q, row_idx_d;
    logic [1:0]          cand_col_q, cand_col_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic                pressed_q, pressed_d;
    logic                pulse_q, pulse_d;

    logic                tick;
    logic                cand_high;
    logic [DEB_W-1:0]    deb_inc;
    logic [1:0]          first_low;

    key_sync #(.WIDTH(KEY_COLS)) u_key_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (kb_col_in),
        .sync_out (col_s)
    );

    always_comb begin
        tick      = (dwell_q == DWELL_LAST);
        cand_high = col_s[cand_col_q];
        deb_inc   = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_ONE;
        first_low = lowest_low(col_s);
    end

    // Row only ever moves on a tick, so wrapping the counter also restarts it per row.
    always_comb begin
        state_d    = state_q;
        dwell_d    = tick ? '0 : dwell_q + DWELL_W'(1);
        deb_d      = deb_q;
        row_idx_d  = row_idx_q;
        cand_col_d = cand_col_q;
        row_d      = row_q;
        col_d      = col_q;
        pressed_d  = pressed_q;
        pulse_d    = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&col_s) begin
                        row_idx_d = row_idx_q + ROW_W'(1);
                    end else begin
                        cand_col_d = first_low;
                        deb_d      = DEB_ONE;
                        if (DEB_MAX == DEB_ONE) begin
                            state_d   = HELD;
                            row_d     = {1'b0, row_idx_q};
                            col_d     = {1'b0, first_low};
                            pressed_d = 1'b1;
                            pulse_d   = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!cand_high) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_d   = HELD;
                            row_d     = {1'b0, row_idx_q};
                            col_d     = {1'b0, cand_col_q};
                            pressed_d = 1'b1;
                            pulse_d   = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        deb_d     = '0;
                        row_idx_d = row_idx_q + ROW_W'(1);
                    end
                end
                HELD: begin
                    if (cand_high) begin
                        deb_d = DEB_ONE;
                        if (DEB_MAX == DEB_ONE) begin
                            state_d   = SCAN;
                            deb_d     = '0;
                            row_d     = IDLE_CODE;
                            col_d     = IDLE_CODE;
                            pressed_d = 1'b0;
                            row_idx_d = row_idx_q + ROW_W'(1);
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (cand_high) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_d   = SCAN;
                            deb_d     = '0;
                            row_d     = IDLE_CODE;
                            col_d     = IDLE_CODE;
                            pressed_d = 1'b0;
                            row_idx_d = row_idx_q + ROW_W'(1);
                        end
                    end else begin
                        // Glitch during release: key is still down, no new strobe.
                        state_d = HELD;
                        deb_d   = DEB_MAX;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            dwell_q    <= '0;
            deb_q      <= '0;
            row_idx_q  <= '0;
            cand_col_q <= '0;
            row_q      <= IDLE_CODE;
            col_q      <= IDLE_CODE;
            pressed_q  <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            deb_q      <= deb_d;
            row_idx_q  <= row_idx_d;
            cand_col_q <= cand_col_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pressed_q  <= pressed_d;
            pulse_q    <= pulse_d;
        end
    end

    assign kb_row_out  = ~(KEY_ROWS'(1) << row_idx_q);
    assign row         = row_q;
    assign col         = col_q;
    assign pressed     = pressed_q;
    assign press_pulse = pulse_q;

endmodule

// File: doc/key_matrix_scan.md
# key_matrix_scan

Scans the 4x4 mole keypad, synchronises and debounces the column returns, and presents the struck key as 3-bit row/column coordinates. It sits directly upstream of the game controller, which compares these coordinates against the random mole position during the game state. It also drives the keypad row lines, and outputs an idle code whenever no debounced key is held.

## Interface
Parameters:
- DWELL, 1000: clk cycles each row is driven before its columns are sampled (min 4).
- DEB_CNT, 10: consecutive agreeing samples required to accept a press or a release (min 1).
- IDLE_CODE, 3'b111: value on `row`/`col` when no key is held.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- kb_col_in  in  4  raw keypad column lines, active-low, externally pulled up; asynchronous to clk.
- kb_row_out  out  4  keypad row drive, active-low; exactly one bit is low at all times.
- row  out  3  debounced row index 0..3, or IDLE_CODE.
- col  out  3  debounced column index 0..3, or IDLE_CODE.
- pressed  out  1  high while a debounced key is held.
- press_pulse  out  1  one-cycle strobe on each newly accepted press.

## Operation
- Synchroniser: two flops on kb_col_in give col_s. Reset value 4'b1111.
- Dwell counter:
  - Counts 0..DWELL-1 and wraps.
  - The count DWELL-1 is the sample tick. All state decisions happen only on sample ticks.
  - The counter restarts at 0 whenever the driven row changes.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. Reset state is SCAN, with row index 0 and kb_row_out=4'b1110.
- SCAN:
  - On a tick with col_s==4'b1111, advance the row index (3 wraps to 0).
  - On a tick with any col_s bit low, latch cand_row=current row and cand_col=lowest-index low bit. Set deb=1 and go to DEBOUNCE. The row drive is held.
- DEBOUNCE:
  - On a tick with col_s[cand_col] low, increment deb.
  - When deb reaches DEB_CNT, go to HELD. Load row=cand_row and col=cand_col, set pressed=1, and pulse press_pulse for one cycle.
  - On a tick with col_s[cand_col] high, go back to SCAN and advance the row.
  - If DEB_CNT=1, the transition to HELD happens on the detecting tick itself.
- HELD:
  - The row drive stays on cand_row.
  - Other columns going low are ignored. Keys in other rows are not visible.
  - On a tick with col_s[cand_col] high, set deb=1 and go to RELEASE.
- RELEASE:
  - On a tick with col_s[cand_col] high, increment deb.
  - When deb reaches DEB_CNT, go to SCAN. Set row=col=IDLE_CODE and pressed=0, and advance the row.
  - On a tick with col_s[cand_col] low, return to HELD. No new press_pulse is generated.
- press_pulse fires at most once per accepted press. Holding a key never retriggers it.
- rst in any state returns every register to its reset value on the next edge. This includes an in-progress press: no pulse is produced.

## Timing
- Reset values: kb_row_out=4'b1110, row=col=IDLE_CODE, pressed=0, press_pulse=0, deb=0, dwell=0.
- Input latency: 2 cycles from a pad change to col_s.
- Press acceptance: DEB_CNT sample ticks after the first tick that sees the key, with ticks spaced DWELL cycles apart while the row is held.
- row, col, pressed and press_pulse update on the same edge. All are registered.
- Worst-case detection: up to 4*DWELL cycles of scan before the key's row is driven.
- deb saturates at DEB_CNT and never wraps. Its width is clog2(DEB_CNT+1).

## Structure
- Shared package `whack_pkg` holds:
  - the scan FSM state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - KEY_ROWS=4 and KEY_COLS=4;
  - the default IDLE_CODE.
- One sub-module, `key_sync`: a 2-flop synchroniser, parameterised width, synchronous reset to all-ones.
- FSM, dwell counter and debounce counter stay in the top module.

## Test plan
All scenarios use DWELL=4 and DEB_CNT=3.
- Reset: assert rst for 2 cycles -> kb_row_out=1110, row=col=7, pressed=0, press_pulse=0. Rows then rotate 1110->1101->1011->0111 every 4 cycles.
- Clean press: model key (2,1), so col bit 1 is low whenever kb_row_out[2]=0 -> press_pulse high exactly 1 cycle, then row=2, col=1, pressed=1. kb_row_out stays 1011 while held, and no second pulse occurs over 100 cycles.
- Bounce: key (2,1) low for 2 ticks, then high -> no press_pulse, row=col=7, scanning resumes at row 3.
- Release with glitch:
  - From HELD, release for 1 tick, then re-press -> stays HELD, no pulse.
  - Then release for 3 ticks -> row=col=7, pressed=0.
- Two keys: (1,1) and (1,3) pressed together -> col=1. Pressing (0,0) while (1,1) is held is ignored.
- Reset mid-operation: assert rst in DEBOUNCE and in HELD -> next cycle all outputs return to their reset values, with no press_pulse.
